// File: rtl/ifid_if.sv
// ----------------------------------------------------------------------------
// ifid_if
// Fetch-to-IF/ID handshake bundle.
//   if_valid : fetch presents an instruction
//   if_instr : fetched instruction word (IW bits)
//   if_pc    : PC of the fetched instruction (PCW bits)
//   if_ready : IF/ID stage can accept this cycle
// Modports: master = fetch side (drives valid/instr/pc),
//           slave  = IF/ID stage (drives ready).
// ----------------------------------------------------------------------------
interface ifid_if #(
    parameter int IW  = 16,
    parameter int PCW = 16
);
    logic           if_valid;
    logic [IW-1:0]  if_instr;
    logic [PCW-1:0] if_pc;
    logic           if_ready;

    modport master (output if_valid, if_instr, if_pc, input if_ready);
    modport slave  (input if_valid, if_instr, if_pc, output if_ready);
endinterface

// File: rtl/ifid_pipe_reg.sv
// ----------------------------------------------------------------------------
// ifid_pipe_reg
// IF/ID pipeline register between fetch and decode. A main slot feeds decode
// and a skid slot absorbs the one extra word that can arrive while decode is
// stalled, so the registered if_ready never has to react combinationally to
// hazard. On flush or when empty the stage presents NOP so control never sees
// a stale opcode.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   fetch (slave)   : if_valid / if_instr / if_pc in, if_ready out
//   hazard          : decode cannot advance this cycle
//   flush           : kill every held instruction
//   id_valid        : main slot holds a live instruction
//   id_instr, id_pc : main-slot instruction (NOP when invalid) and PC
//   cntrl_input, reg_rd, reg_rs, reg_rt, branch_cond, arith_imm,
//   load_save_imm, call_target : field slices of id_instr
//   stall_cnt       : saturating count of cycles with hazard && id_valid
//   bubble_cnt      : saturating count of cycles with !id_valid && !hazard
//
// Build option: define IFID_PERF_CNT_EN to implement the two performance
// counters; otherwise they are tied to zero and no counter flops exist.
// ----------------------------------------------------------------------------
module ifid_pipe_reg #(
    parameter int            IW  = 16,
    parameter int            PCW = 16,
    parameter logic [IW-1:0] NOP = 16'hF000,
    parameter int            CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    ifid_if.slave          fetch,
    input  logic           hazard,
    input  logic           flush,
    output logic           id_valid,
    output logic [IW-1:0]  id_instr,
    output logic [PCW-1:0] id_pc,
    output logic [3:0]     cntrl_input,
    output logic [3:0]     reg_rd,
    output logic [3:0]     reg_rs,
    output logic [3:0]     reg_rt,
    output logic [2:0]     branch_cond,
    output logic [3:0]     arith_imm,
    output logic [7:0]     load_save_imm,
    output logic [11:0]    call_target,
    output logic [CW-1:0]  stall_cnt,
    output logic [CW-1:0]  bubble_cnt
);

    logic           main_v;
    logic           skid_v;
    logic [IW-1:0]  main_instr;
    logic [IW-1:0]  skid_instr;
    logic [PCW-1:0] main_pc;
    logic [PCW-1:0] skid_pc;

    logic accept;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    // if_ready is a flop output: it is simply the inverse of the skid flag.
    assign fetch.if_ready = ~skid_v;
    assign accept         = fetch.if_valid & ~skid_v;

    // Slot steering. Flush overrides everything, hazard freezes main, and an
    // advance drains the skid before any new word may enter.
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            if (hazard) begin
                if (accept) begin
                    if (main_v) load_skid    = 1'b1;
                    else        load_main_in = 1'b1;
                end
            end else if (skid_v) begin
                load_main_skid = 1'b1;
            end else if (accept) begin
                load_main_in = 1'b1;
            end
        end
    end

    // Control state and the visible PC (PC must read 0 out of reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v  <= 1'b0;
            skid_v  <= 1'b0;
            main_pc <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            if (load_skid)           skid_v <= 1'b1;
            else if (load_main_skid) skid_v <= 1'b0;

            if (load_main_in || load_main_skid) main_v <= 1'b1;
            else if (!hazard)                   main_v <= 1'b0;

            if (load_main_in)        main_pc <= fetch.if_pc;
            else if (load_main_skid) main_pc <= skid_pc;
        end
    end

    // Instruction payloads carry no reset: they are only observed while the
    // matching valid flag is set.
    always_ff @(posedge clk) begin
        if (load_main_in)        main_instr <= fetch.if_instr;
        else if (load_main_skid) main_instr <= skid_instr;
        if (load_skid) begin
            skid_instr <= fetch.if_instr;
            skid_pc    <= fetch.if_pc;
        end
    end

    assign id_valid = main_v;
    assign id_instr = main_v ? main_instr : NOP;
    assign id_pc    = main_pc;

    assign cntrl_input   = id_instr[15:12];
    assign reg_rd        = id_instr[11:8];
    assign reg_rs        = id_instr[7:4];
    assign reg_rt        = id_instr[3:0];
    assign branch_cond   = id_instr[10:8];
    assign arith_imm     = id_instr[3:0];
    assign load_save_imm = id_instr[7:0];
    assign call_target   = id_instr[11:0];

`ifdef IFID_PERF_CNT_EN
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CW-1:0] stall_q;
    logic [CW-1:0] bubble_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (hazard && main_v)   stall_q  <= sat_inc(stall_q);
            if (!main_v && !hazard) bubble_q <= sat_inc(bubble_q);
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_ifid_pipe_reg
// Bench for ifid_pipe_reg. The reference model treats the stage as an
// ordered queue of at most two in-flight words: an accept appends, decode
// taking a word (valid, no hazard, no flush) removes the head, flush empties
// it. Everything the stage shows is derived from that queue. A second DUT
// with CW = 2 shares the stimulus to exercise counter saturation.
// ----------------------------------------------------------------------------
module tb_ifid_pipe_reg;

    localparam logic [15:0] TB_NOP = 16'hF000;
`ifdef IFID_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hazard = 1'b0;
    logic flush  = 1'b0;

    always #5 clk = ~clk;

    ifid_if #(.IW(16), .PCW(16)) bus ();
    ifid_if #(.IW(16), .PCW(16)) bus2 ();

    assign bus2.if_valid = bus.if_valid;
    assign bus2.if_instr = bus.if_instr;
    assign bus2.if_pc    = bus.if_pc;

    logic        id_valid, s_id_valid;
    logic [15:0] id_instr, s_id_instr, id_pc, s_id_pc;
    logic [3:0]  cntrl_input, reg_rd, reg_rs, reg_rt, arith_imm;
    logic [2:0]  branch_cond;
    logic [7:0]  load_save_imm;
    logic [11:0] call_target;
    logic [15:0] stall_cnt, bubble_cnt;
    logic [3:0]  s_cntrl, s_rd, s_rs, s_rt, s_ai;
    logic [2:0]  s_bc;
    logic [7:0]  s_ls;
    logic [11:0] s_ct;
    logic [1:0]  s_stall_cnt, s_bubble_cnt;

    ifid_pipe_reg #(.IW(16), .PCW(16), .NOP(16'hF000), .CW(16)) dut (
        .clk(clk), .rst(rst), .fetch(bus.slave), .hazard(hazard), .flush(flush),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .cntrl_input(cntrl_input), .reg_rd(reg_rd), .reg_rs(reg_rs), .reg_rt(reg_rt),
        .branch_cond(branch_cond), .arith_imm(arith_imm),
        .load_save_imm(load_save_imm), .call_target(call_target),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    ifid_pipe_reg #(.IW(16), .PCW(16), .NOP(16'hF000), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .fetch(bus2.slave), .hazard(hazard), .flush(flush),
        .id_valid(s_id_valid), .id_instr(s_id_instr), .id_pc(s_id_pc),
        .cntrl_input(s_cntrl), .reg_rd(s_rd), .reg_rs(s_rs), .reg_rt(s_rt),
        .branch_cond(s_bc), .arith_imm(s_ai),
        .load_save_imm(s_ls), .call_target(s_ct),
        .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    word_t q[$];
    logic [15:0] m_pc = '0;
    int m_stall = 0, m_bubble = 0, s_stall = 0, s_bubble = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_pc = '0;
            m_stall = 0; m_bubble = 0; s_stall = 0; s_bubble = 0;
        end else begin
            automatic bit    live = (q.size() > 0);
            automatic bit    acc  = bus.if_valid && (q.size() < 2);
            automatic word_t w;
            w.instr = bus.if_instr;
            w.pc    = bus.if_pc;
            if (hazard && live) begin
                if (m_stall < 65535) m_stall++;
                if (s_stall < 3)     s_stall++;
            end
            if (!live && !hazard) begin
                if (m_bubble < 65535) m_bubble++;
                if (s_bubble < 3)     s_bubble++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (!hazard && live) void'(q.pop_front());
                if (acc) q.push_back(w);
                if (q.size() > 0) m_pc = q[0].pc;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        automatic logic [15:0] e = (q.size() > 0) ? q[0].instr : TB_NOP;
        chk("id_valid", id_valid, q.size() > 0);
        chk("if_ready", bus.if_ready, q.size() < 2);
        chk("id_instr", id_instr, e);
        chk("id_pc", id_pc, m_pc);
        chk("cntrl_input", cntrl_input, e[15:12]);
        chk("reg_rd", reg_rd, e[11:8]);
        chk("reg_rs", reg_rs, e[7:4]);
        chk("reg_rt", reg_rt, e[3:0]);
        chk("branch_cond", branch_cond, e[10:8]);
        chk("arith_imm", arith_imm, e[3:0]);
        chk("load_save_imm", load_save_imm, e[7:0]);
        chk("call_target", call_target, e[11:0]);
        chk("stall_cnt", stall_cnt, CNT_EN ? m_stall : 0);
        chk("bubble_cnt", bubble_cnt, CNT_EN ? m_bubble : 0);
        chk("sat_stall_cnt", s_stall_cnt, CNT_EN ? s_stall : 0);
        chk("sat_bubble_cnt", s_bubble_cnt, CNT_EN ? s_bubble : 0);
        chk("sat_id_instr", s_id_instr, e);
    end

    // ---------------- stimulus ----------------
    // Set inputs just after a falling edge, then return at the next falling
    // edge so the rising edge in between has taken effect.
    task automatic cyc(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic hz, input logic fl);
        #1;
        bus.if_valid = v;
        bus.if_instr = ins;
        bus.if_pc    = pc;
        hazard       = hz;
        flush        = fl;
        @(negedge clk);
    endtask

    initial begin
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;

        // Reset state while held
        @(negedge clk);
        @(negedge clk);
        chk("rst id_valid", id_valid, 0);
        chk("rst cntrl_input", cntrl_input, 4'hF);
        chk("rst if_ready", bus.if_ready, 1);
        chk("rst id_pc", id_pc, 0);

        // Release with fetch idle
        #1 rst = 1'b0;
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("rel id_valid", id_valid, 0);
        chk("rel cntrl_input", cntrl_input, 4'hF);
        chk("rel if_ready", bus.if_ready, 1);
        chk("rel id_pc", id_pc, 0);

        // Counters: 3 stall cycles, then 2 idle cycles
        cyc(1'b1, 16'h5A5A, 16'h0010, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("stall_cnt=3", stall_cnt, CNT_EN ? 3 : 0);
        chk("bubble_cnt=2", bubble_cnt, CNT_EN ? 2 : 0);
        chk("sat stall=3", s_stall_cnt, CNT_EN ? 3 : 0);
        chk("sat bubble=2", s_bubble_cnt, CNT_EN ? 2 : 0);
        cyc(1'b1, 16'h6B6B, 16'h0011, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("stall_cnt=8", stall_cnt, CNT_EN ? 8 : 0);
        chk("sat stall held", s_stall_cnt, CNT_EN ? 3 : 0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Back-to-back stream
        cyc(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0);
        chk("stream A instr", id_instr, 16'h1234);
        chk("stream A reg_rd", reg_rd, 4'h2);
        chk("stream A reg_rs", reg_rs, 4'h3);
        chk("stream A reg_rt", reg_rt, 4'h4);
        cyc(1'b1, 16'h2345, 16'h0001, 1'b0, 1'b0);
        chk("stream B instr", id_instr, 16'h2345);
        chk("stream B pc", id_pc, 16'h0001);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("stream idle pc held", id_pc, 16'h0001);

        // One-cycle hazard while streaming A, B, C
        cyc(1'b1, 16'h3A01, 16'h000A, 1'b0, 1'b0);
        chk("hz A", id_instr, 16'h3A01);
        cyc(1'b1, 16'h3B02, 16'h000B, 1'b1, 1'b0);
        chk("hz A held", id_instr, 16'h3A01);
        chk("hz skid ready", bus.if_ready, 0);
        cyc(1'b1, 16'h3C03, 16'h000C, 1'b0, 1'b0);
        chk("hz B", id_instr, 16'h3B02);
        chk("hz ready back", bus.if_ready, 1);
        cyc(1'b1, 16'h3C03, 16'h000C, 1'b0, 1'b0);
        chk("hz C", id_instr, 16'h3C03);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Flush with main and skid full, fetch still offering a word
        cyc(1'b1, 16'h4101, 16'h0014, 1'b0, 1'b0);
        cyc(1'b1, 16'h4202, 16'h0015, 1'b1, 1'b0);
        cyc(1'b1, 16'h4303, 16'h0016, 1'b1, 1'b1);
        chk("fl id_valid", id_valid, 0);
        chk("fl id_instr", id_instr, 16'hF000);
        chk("fl if_ready", bus.if_ready, 1);
        chk("fl id_pc", id_pc, 16'h0014);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("fl no word", id_valid, 0);

        // Flush racing a real accept into an occupied main slot
        cyc(1'b1, 16'h4404, 16'h001E, 1'b0, 1'b0);
        cyc(1'b1, 16'h4505, 16'h001F, 1'b0, 1'b1);
        chk("fl2 id_valid", id_valid, 0);
        chk("fl2 id_pc", id_pc, 16'h001E);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("fl2 dropped", id_valid, 0);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
        end
        repeat (2) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-stall with the skid full
        cyc(1'b1, 16'h7101, 16'h0028, 1'b1, 1'b0);
        cyc(1'b1, 16'h7202, 16'h0029, 1'b1, 1'b0);
        chk("pre-rst ready", bus.if_ready, 0);
        chk("pre-rst pc", id_pc, 16'h0028);
        bus.if_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst id_valid", id_valid, 0);
        chk("arst id_instr", id_instr, 16'hF000);
        chk("arst if_ready", bus.if_ready, 1);
        chk("arst id_pc", id_pc, 0);
        chk("arst stall_cnt", stall_cnt, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
